// File: rtl/tlul_host_port_if.sv
// TL-UL link types and the core-side request/response bundle of the host port.
// The core drives through the master modport and the bridge uses the slave modport.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

interface tlul_host_port_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/tlul_host_port.sv
// TL-UL initiator: maps core request/grant onto the A channel and returns
// D-channel responses in order, with rolling source IDs and an in-flight count.
module tlul_host_port
    import tlul_pkg::*;
#(
    parameter int Outstanding = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tlul_host_port_if.slave   core,
    output tl_h2d_t           tl_o,
    input  tl_d2h_t           tl_i
);

    localparam int IdW  = $clog2(Outstanding);
    localparam int CntW = $clog2(Outstanding + 1);

    logic [CntW-1:0] outCnt_q, outCnt_d;
    logic [IdW-1:0]  wrId_q, wrId_d;
    logic [IdW-1:0]  rdId_q, rdId_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic full;
    logic aValid;
    logic aHs;
    logic dHs;
    logic unused_tl;

    // a_valid only looks at the local count, never at d_valid, so there is no D->A path.
    assign full   = (outCnt_q == CntW'(Outstanding));
    assign aValid = core.req_i & ~full;
    assign aHs    = aValid & tl_i.a_ready;
    assign dHs    = tl_i.d_valid;

    always_comb begin : aChannel
        tl_o           = '0;
        tl_o.a_valid   = aValid;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_address = {core.addr_i[31:2], 2'b00};
        tl_o.a_mask    = core.be_i;
        tl_o.a_data    = core.we_i ? core.wdata_i : 32'h0;
        tl_o.a_source[IdW-1:0] = wrId_q;
        if (!core.we_i) begin
            tl_o.a_opcode = Get;
        end else if (core.be_i == 4'hF) begin
            tl_o.a_opcode = PutFullData;
        end else begin
            tl_o.a_opcode = PutPartialData;
        end
        tl_o.d_ready = 1'b1;
    end

    always_comb begin : nextState
        wrId_d   = wrId_q;
        rdId_d   = rdId_q;
        outCnt_d = outCnt_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;

        if (aHs) begin
            wrId_d = wrId_q + IdW'(1);
        end

        // Responses must come back in issue order; anything unexpected is flagged but still retired.
        if (dHs) begin
            rdId_d   = rdId_q + IdW'(1);
            rvalid_d = 1'b1;
            rdata_d  = (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0;
            err_d    = tl_i.d_error
                     | (tl_i.d_source[IdW-1:0] != rdId_q)
                     | (outCnt_q == '0);
        end

        unique case ({aHs, dHs})
            2'b10: outCnt_d = outCnt_q + CntW'(1);
            2'b01: begin
                if (outCnt_q != '0) begin
                    outCnt_d = outCnt_q - CntW'(1);
                end
            end
            default: outCnt_d = outCnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : stateReg
        if (!rst_ni) begin
            outCnt_q <= '0;
            wrId_q   <= '0;
            rdId_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            outCnt_q <= outCnt_d;
            wrId_q   <= wrId_d;
            rdId_q   <= rdId_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign core.gnt_o    = aHs;
    assign core.rvalid_o = rvalid_q;
    assign core.rdata_o  = rdata_q;
    assign core.err_o    = err_q;

    assign unused_tl = ^{core.addr_i[1:0], tl_i.d_param, tl_i.d_size,
                         tl_i.d_source[7:IdW], tl_i.d_sink, tl_i.d_user};

endmodule
